// File: rtl/dht11_sensor_model.sv
// DHT11 responder: detects a host start pulse on the open-drain line and answers
// with the response preamble and a 40-bit humidity/temperature frame.
module dht11_sensor_model #(
    parameter int unsigned CLKS_PER_US  = 50,
    parameter int unsigned START_MIN_US = 18000,
    parameter int unsigned RESP_DLY_US  = 30,
    parameter int unsigned RESP_LO_US   = 80,
    parameter int unsigned RESP_HI_US   = 80,
    parameter int unsigned BIT_LO_US    = 50,
    parameter int unsigned BIT0_HI_US   = 26,
    parameter int unsigned BIT1_HI_US   = 70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        HOST_LO,
        RESP_DLY,
        RESP_LO,
        RESP_HI,
        BIT_LO,
        BIT_HI,
        END_LO
    } state_t;

    localparam logic [31:0] START_CYC    = 32'(START_MIN_US * CLKS_PER_US);
    localparam logic [31:0] RESP_DLY_CYC = 32'(RESP_DLY_US * CLKS_PER_US);
    localparam logic [31:0] RESP_LO_CYC  = 32'(RESP_LO_US * CLKS_PER_US);
    localparam logic [31:0] RESP_HI_CYC  = 32'(RESP_HI_US * CLKS_PER_US);
    localparam logic [31:0] BIT_LO_CYC   = 32'(BIT_LO_US * CLKS_PER_US);
    localparam logic [31:0] BIT0_HI_CYC  = 32'(BIT0_HI_US * CLKS_PER_US);
    localparam logic [31:0] BIT1_HI_CYC  = 32'(BIT1_HI_US * CLKS_PER_US);

    state_t      state, state_n;
    logic [1:0]  sync;
    logic        din_s;
    logic [31:0] cnt;
    logic [5:0]  bit_idx;
    logic [39:0] shreg;
    logic [7:0]  chk;
    logic [31:0] phase_len;
    logic        phase_end;
    logic        load;
    logic        bit_end;
    logic        done_n;
    logic        start_ok;

    assign din_s = sync[1];
    assign chk   = hum_int + hum_dec + tmp_int + tmp_dec;

    always_comb begin
        phase_len = '0;
        case (state)
            RESP_DLY: phase_len = RESP_DLY_CYC;
            RESP_LO:  phase_len = RESP_LO_CYC;
            RESP_HI:  phase_len = RESP_HI_CYC;
            BIT_LO:   phase_len = BIT_LO_CYC;
            BIT_HI:   phase_len = shreg[39] ? BIT1_HI_CYC : BIT0_HI_CYC;
            END_LO:   phase_len = BIT_LO_CYC;
            default:  phase_len = '0;
        endcase
    end

    assign phase_end = (cnt == phase_len - 32'd1);

    // cnt trails the host low time by the IDLE detection cycle, hence the +1
    assign start_ok = ({1'b0, cnt} + 33'd1) >= {1'b0, START_CYC};

    always_comb begin
        state_n = state;
        dht_oe  = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!din_s) state_n = HOST_LO;
            end
            HOST_LO: begin
                busy = 1'b0;
                if (din_s) state_n = start_ok ? RESP_DLY : IDLE;
            end
            RESP_DLY: begin
                if (phase_end) state_n = RESP_LO;
            end
            RESP_LO: begin
                dht_oe = 1'b1;
                if (phase_end) state_n = RESP_HI;
            end
            RESP_HI: begin
                if (phase_end) state_n = BIT_LO;
            end
            BIT_LO: begin
                dht_oe = 1'b1;
                if (phase_end) state_n = BIT_HI;
            end
            BIT_HI: begin
                if (phase_end) state_n = (bit_idx == 6'd39) ? END_LO : BIT_LO;
            end
            END_LO: begin
                dht_oe = 1'b1;
                if (phase_end) state_n = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = IDLE;
            end
        endcase
        if (!en) state_n = IDLE;
    end

    assign load    = (state == HOST_LO) && (state_n == RESP_DLY);
    assign bit_end = (state == BIT_HI) && phase_end && en;
    assign done_n  = (state == END_LO) && phase_end && en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sync    <= 2'b11;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            done    <= 1'b0;
        end else begin
            sync  <= {sync[0], dht_in};
            state <= state_n;
            done  <= done_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 32'd1;
            end
            if (load) begin
                shreg   <= {hum_int, hum_dec, tmp_int, tmp_dec, chk};
                bit_idx <= '0;
            end else if (bit_end) begin
                shreg   <= {shreg[38:0], 1'b0};
                bit_idx <= bit_idx + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Bench for dht11_sensor_model: drives host start pulses and decodes the
// response from dht_oe pulse widths against a frame/timing reference model.
module tb_dht11_sensor_model;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dht_in = 1'b1;
    logic [7:0] hum_int = '0;
    logic [7:0] hum_dec = '0;
    logic [7:0] tmp_int = '0;
    logic [7:0] tmp_dec = '0;
    logic       dht_oe;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dht11_sensor_model #(
        .CLKS_PER_US (1),
        .START_MIN_US(100)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .hum_int(hum_int),
        .hum_dec(hum_dec),
        .tmp_int(tmp_int),
        .tmp_dec(tmp_dec),
        .dht_in (dht_in),
        .dht_oe (dht_oe),
        .busy   (busy),
        .done   (done)
    );

    // Line monitor: records dht_oe run lengths from the first pull-down until done.
    bit   mon_on = 1'b0;
    bit   mon_prev = 1'b0;
    int   runs[$];
    bit   started = 1'b0;
    bit   closed = 1'b0;
    bit   busy_seen = 1'b0;
    int   first_rise = -1;
    int   done_cyc = -1;
    int   done_cnt = 0;
    int   run_len = 0;
    logic prev_oe = 1'b0;

    always @(negedge clk) begin
        if (mon_on && !mon_prev) begin
            runs.delete();
            started    = 1'b0;
            closed     = 1'b0;
            busy_seen  = 1'b0;
            first_rise = -1;
            done_cyc   = -1;
            done_cnt   = 0;
            run_len    = 0;
        end
        mon_prev = mon_on;
        if (mon_on) begin
            if (busy === 1'b1) busy_seen = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!started) begin
                if (dht_oe === 1'b1) begin
                    started    = 1'b1;
                    first_rise = cyc;
                    prev_oe    = 1'b1;
                    run_len    = 1;
                end
            end else if (!closed) begin
                if (dht_oe === prev_oe) begin
                    run_len++;
                end else begin
                    runs.push_back(run_len);
                    prev_oe = dht_oe;
                    run_len = 1;
                end
                if (done === 1'b1) closed = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
        int          sum;
        logic [7:0]  s;
        sum = int'(a) + int'(b) + int'(c) + int'(d);
        s   = 8'(sum % 256);
        return {a, b, c, d, s};
    endfunction

    function automatic int hi_len(input logic [39:0] f, input int i);
        return f[39-i] ? 70 : 26;
    endfunction

    function automatic int model_len(input logic [39:0] f);
        int t;
        t = 30 + 80 + 80 + 41 * 50;
        for (int i = 0; i < 40; i++) t += hi_len(f, i);
        return t;
    endfunction

    // Offset from the release edge to the start of bit k's low slot.
    function automatic int bit_start(input logic [39:0] f, input int k);
        int t;
        t = 2 + 30 + 80 + 80;
        for (int i = 0; i < k; i++) t += 50 + hi_len(f, i);
        return t;
    endfunction

    task automatic tick_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start_pulse(input int n, output int rel);
        @(posedge clk);
        #1 dht_in = 1'b0;
        repeat (n) @(posedge clk);
        #1 dht_in = 1'b1;
        rel = cyc + 1;
    endtask

    task automatic pre_checks(input string tag, input int rel);
        tick_to(rel + 1);
        check({tag, "_busy_before"}, 64'(busy), 64'(1'b0));
        tick_to(rel + 2);
        check({tag, "_busy_rise"}, 64'(busy), 64'(1'b1));
    endtask

    task automatic run_and_check(input string tag, input logic [39:0] f, input int rel,
                                 output logic [39:0] dec);
        bit widths_ok;
        while (!closed && cyc < rel + 6000) @(negedge clk);
        repeat (20) @(negedge clk);
        check({tag, "_complete"}, 64'(closed), 64'(1'b1));
        check({tag, "_runs"}, 64'(runs.size()), 64'(83));
        check({tag, "_first_rise"}, 64'(first_rise), 64'(rel + 32));
        dec = '0;
        for (int i = 0; i < 40; i++)
            if (3 + 2 * i < runs.size()) dec[39-i] = (runs[3+2*i] > 48);
        check({tag, "_frame"}, 64'(dec), 64'(f));
        widths_ok = (runs.size() == 83);
        if (widths_ok) begin
            widths_ok = (runs[0] == 80) && (runs[1] == 80) && (runs[82] == 50);
            for (int i = 0; i < 40; i++)
                if (runs[2+2*i] != 50 || runs[3+2*i] != hi_len(f, i)) widths_ok = 1'b0;
        end
        check({tag, "_widths"}, 64'(widths_ok), 64'(1'b1));
        check({tag, "_done_time"}, 64'(done_cyc), 64'(rel + 2 + model_len(f)));
        check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
        check({tag, "_busy_after"}, 64'(busy), 64'(1'b0));
        check({tag, "_oe_after"}, 64'(dht_oe), 64'(1'b0));
        mon_on = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        hum_int = a;
        hum_dec = b;
        tmp_int = c;
        tmp_dec = d;
    endtask

    task automatic random_frame(input string tag);
        logic [39:0] f;
        logic [39:0] dec;
        int          rel;
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        f = model_frame(hum_int, hum_dec, tmp_int, tmp_dec);
        mon_on = 1'b1;
        start_pulse(100 + int'($urandom_range(0, 40)), rel);
        pre_checks(tag, rel);
        run_and_check(tag, f, rel, dec);
    endtask

    logic [39:0] f;
    logic [39:0] dec;
    int          rel;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_oe", 64'(dht_oe), 64'(1'b0));
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_done", 64'(done), 64'(1'b0));
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (5) @(negedge clk);

        set_inputs(8'h37, 8'h00, 8'h19, 8'h05);
        f = model_frame(hum_int, hum_dec, tmp_int, tmp_dec);
        mon_on = 1'b1;
        start_pulse(120, rel);
        pre_checks("nominal", rel);
        run_and_check("nominal", f, rel, dec);
        check("nominal_chk", 64'(dec[7:0]), 64'(8'h55));

        set_inputs(8'hFF, 8'hFF, 8'h01, 8'h02);
        f = model_frame(hum_int, hum_dec, tmp_int, tmp_dec);
        mon_on = 1'b1;
        start_pulse(110, rel);
        pre_checks("wrap", rel);
        run_and_check("wrap", f, rel, dec);
        check("wrap_chk", 64'(dec[7:0]), 64'(8'h01));

        random_frame("rand_a");
        random_frame("rand_b");

        mon_on = 1'b1;
        start_pulse(99, rel);
        tick_to(rel + 300);
        check("short_no_oe", 64'(started), 64'(1'b0));
        check("short_no_busy", 64'(busy_seen), 64'(1'b0));
        check("short_no_done", 64'(done_cnt), 64'(0));
        mon_on = 1'b0;
        @(negedge clk);
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        f = model_frame(hum_int, hum_dec, tmp_int, tmp_dec);
        mon_on = 1'b1;
        start_pulse(100, rel);
        pre_checks("min_start", rel);
        run_and_check("min_start", f, rel, dec);

        set_inputs(8'h37, 8'($urandom), 8'($urandom), 8'($urandom));
        f = model_frame(hum_int, hum_dec, tmp_int, tmp_dec);
        mon_on = 1'b1;
        start_pulse(105, rel);
        pre_checks("latch", rel);
        tick_to(rel + bit_start(f, 3) + 5);
        hum_int = 8'hAA;
        run_and_check("latch", f, rel, dec);
        check("latch_hum", 64'(dec[39:32]), 64'(8'h37));

        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        f = model_frame(hum_int, hum_dec, tmp_int, tmp_dec);
        mon_on = 1'b1;
        start_pulse(100, rel);
        pre_checks("abort", rel);
        tick_to(rel + bit_start(f, 20) + 10);
        check("abort_oe_pre", 64'(dht_oe), 64'(1'b1));
        en = 1'b0;
        @(negedge clk);
        check("abort_oe", 64'(dht_oe), 64'(1'b0));
        check("abort_busy", 64'(busy), 64'(1'b0));
        repeat (200) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(0));
        en = 1'b1;
        mon_on = 1'b0;
        @(negedge clk);
        random_frame("after_abort");

        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        mon_on = 1'b1;
        start_pulse(100, rel);
        pre_checks("rst", rel);
        tick_to(rel + 32 + 10);
        check("rst_oe_pre", 64'(dht_oe), 64'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_oe", 64'(dht_oe), 64'(1'b0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", 64'(done_cnt), 64'(0));
        mon_on = 1'b0;
        @(negedge clk);
        random_frame("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
